// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer logic: Gray/binary
// conversion and the synchronizer depth used on both sides.
package fifo_pkg;

  localparam int SYNC_STAGES = 2;

  // Binary to Gray; the result is masked to w bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return ((b >> 1) ^ b) & mask;
  endfunction

  // Gray to binary; each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
    logic [31:0] mask;
    logic [31:0] b;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    b    = g & mask;
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i] ^ b[i+1];
    end
    return b & mask;
  endfunction

endpackage

// File: rtl/fifo_rptr_empty_sync_w2r.sv
// Multi-flop synchronizer bringing the Gray write pointer into rclk.
// Only one bit of a Gray pointer changes per write, so each stage holds
// either the old or the new pointer, never a mix.
module sync_w2r
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = 3
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic [ADDRSIZE:0] wptr,
  output logic [ADDRSIZE:0] rq2_wptr
);

  logic [ADDRSIZE:0] sync_q [SYNC_STAGES];

  // Shift the write pointer through the synchronizer chain; async clear.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rq2_wptr = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer and status controller of the dual-clock FIFO.
// Keeps binary/Gray read pointers and derives registered empty,
// almost-empty, occupancy and sticky underflow from the synchronized
// write pointer. Status is computed from the next pointer so the empty
// flag rises on the same edge as the read that drains the last entry.
module fifo_rptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE  = 3,
  parameter int AE_THRESH = 1
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                rundf
);

  localparam int                PW   = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AE_T = PW'(AE_THRESH);

  logic [ADDRSIZE:0] rq2_wptr;
  logic [ADDRSIZE:0] rbin_q,   rbin_d;
  logic [ADDRSIZE:0] rgray_q,  rgray_d;
  logic [ADDRSIZE:0] rlevel_q, rlevel_d;
  logic              rempty_q, rempty_d;
  logic              raempty_q, raempty_d;
  logic              rundf_q,  rundf_d;
  logic              accept;
  logic [ADDRSIZE:0] wbin_sync;

  sync_w2r #(.ADDRSIZE(ADDRSIZE)) u_sync_w2r (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .wptr     (wptr),
    .rq2_wptr (rq2_wptr)
  );

  // Next pointer and status; a read while empty is dropped and flagged.
  always_comb begin
    accept    = rinc & ~rempty_q;
    rbin_d    = rbin_q + PW'(accept);
    rgray_d   = PW'(bin2gray(32'(rbin_d), PW));
    wbin_sync = PW'(gray2bin(32'(rq2_wptr), PW));
    rlevel_d  = wbin_sync - rbin_d;
    rempty_d  = (rgray_d == rq2_wptr);
    raempty_d = (rlevel_d <= AE_T);
    rundf_d   = rundf_q | (rinc & rempty_q);
  end

  // Pointer and status registers, all updated on the same edge.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rgray_q   <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      rundf_q   <= 1'b0;
    end else begin
      rbin_q    <= rbin_d;
      rgray_q   <= rgray_d;
      rlevel_q  <= rlevel_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
      rundf_q   <= rundf_d;
    end
  end

  assign rptr    = rgray_q;
  assign raddr   = rbin_q[ADDRSIZE-1:0];
  assign rempty  = rempty_q;
  assign raempty = raempty_q;
  assign rlevel  = rlevel_q;
  assign rundf   = rundf_q;

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Directed bench for the read-side FIFO pointer controller (ADDRSIZE=3, AE_THRESH=1).
module tb_fifo_rptr_empty;

  logic       rclk;
  logic       rrst_n;
  logic       rinc;
  logic [3:0] wptr;
  logic [3:0] rptr;
  logic [2:0] raddr;
  logic       rempty;
  logic       raempty;
  logic [3:0] rlevel;
  logic       rundf;

  int errors = 0;
  int checks = 0;

  fifo_rptr_empty #(.ADDRSIZE(3), .AE_THRESH(1)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rinc    (rinc),
    .wptr    (wptr),
    .rptr    (rptr),
    .raddr   (raddr),
    .rempty  (rempty),
    .raempty (raempty),
    .rlevel  (rlevel),
    .rundf   (rundf)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] gray4(input int n);
    logic [3:0] b;
    b = 4'(n);
    return (b >> 1) ^ b;
  endfunction

  // Advance one rclk edge and settle 1 time unit past it.
  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] wp);
    rinc   = 1'b0;
    wptr   = wp;
    rrst_n = 1'b0;
    #12;
    step();
    rrst_n = 1'b1;
  endtask

  initial begin
    rrst_n = 1'b1;
    rinc   = 1'b0;
    wptr   = 4'b0000;
    #3;

    // Reset with a live write pointer of binary 4
    rrst_n = 1'b0;
    wptr   = 4'b0110;
    #1;
    chk("rst_rempty",  rempty,  1);
    chk("rst_raempty", raempty, 1);
    chk("rst_rlevel",  rlevel,  0);
    chk("rst_rptr",    rptr,    0);
    chk("rst_rundf",   rundf,   0);
    step(); step();
    chk("rst_hold_rempty", rempty, 1);
    rrst_n = 1'b1;
    step();
    chk("sync_e1_rempty", rempty, 1);
    step();
    chk("sync_e2_rempty", rempty, 1);
    step();
    chk("sync_e3_rempty",  rempty,  0);
    chk("sync_e3_rlevel",  rlevel,  4);
    chk("sync_e3_raempty", raempty, 0);

    // Drain five entries
    do_reset(4'b0000);
    wptr = 4'b0111;
    step(); step(); step();
    chk("drain_pre_level", rlevel, 5);
    chk("drain_pre_raddr", raddr,  0);
    rinc = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      step();
      chk($sformatf("drain%0d_raddr", j),   raddr,   j);
      chk($sformatf("drain%0d_rlevel", j),  rlevel,  5 - j);
      chk($sformatf("drain%0d_raempty", j), raempty, (5 - j) <= 1 ? 1 : 0);
      chk($sformatf("drain%0d_rempty", j),  rempty,  j == 5 ? 1 : 0);
    end
    rinc = 1'b0;
    chk("drain_rptr", rptr, 4'b0111);

    // Underflow: read while empty is ignored but flagged
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    chk("undf_rptr",  rptr,  4'b0111);
    chk("undf_raddr", raddr, 5);
    chk("undf_rundf", rundf, 1);
    step(); step(); step();
    chk("undf_sticky", rundf, 1);
    chk("undf_level",  rlevel, 0);
    do_reset(4'b0000);
    chk("undf_clear", rundf, 0);

    // Wrap: prefill 4, then write and read every cycle for 20 cycles
    wptr = 4'b0110;
    step(); step(); step();
    chk("wrap_pre_level", rlevel, 4);
    for (int k = 1; k <= 20; k++) begin
      wptr = gray4(4 + k);
      rinc = 1'b1;
      step();
      chk($sformatf("wrap%0d_rlevel", k), rlevel, k == 1 ? 3 : 2);
      chk($sformatf("wrap%0d_raddr", k),  raddr,  k % 8);
      if (k == 15) chk("wrap15_rptr", rptr, 4'b1000);
      if (k == 16) chk("wrap16_rptr", rptr, 4'b0000);
    end
    rinc = 1'b0;
    step(); step(); step();
    chk("wrap_end_level", rlevel, 4);
    chk("wrap_end_rptr",  rptr,   4'b0110);
    chk("wrap_end_empty", rempty, 0);

    // Full FIFO: eight entries, then drain completely
    do_reset(4'b0000);
    wptr = 4'b1100;
    step(); step(); step();
    chk("full_level",  rlevel, 8);
    chk("full_rempty", rempty, 0);
    rinc = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk($sformatf("full%0d_rlevel", j),  rlevel,  8 - j);
      chk($sformatf("full%0d_raempty", j), raempty, (8 - j) <= 1 ? 1 : 0);
    end
    rinc = 1'b0;
    chk("full_end_rempty", rempty, 1);
    chk("full_end_rptr",   rptr,   4'b1100);
    chk("full_end_rundf",  rundf,  0);

    // Async reset between edges during a read stream
    do_reset(4'b0000);
    wptr = 4'b1100;
    step(); step(); step();
    rinc = 1'b1;
    step(); step(); step();
    chk("arst_pre_raddr", raddr, 3);
    #2;
    rrst_n = 1'b0;
    #1;
    chk("arst_raddr",   raddr,   0);
    chk("arst_rptr",    rptr,    0);
    chk("arst_rempty",  rempty,  1);
    chk("arst_raempty", raempty, 1);
    chk("arst_rlevel",  rlevel,  0);
    rinc = 1'b0;
    rrst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
